// File: rtl/bg_pixel_fetch_if.sv
// Sprite-ROM read port between the background pixel fetcher (master) and the ROM (slave).
// Handshake: no back-pressure; mem_rd is a one-cycle strobe qualifying mem_addr, and mem_data
// is valid exactly MEM_LAT cycles after that strobe, with no valid/ready return signal.
interface bg_pixel_fetch_if #(
    parameter int ADDR_W = 18,
    parameter int IDX_W  = 4
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [IDX_W-1:0]  mem_data;

    modport master (output mem_rd, output mem_addr, input mem_data);
    modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/bg_pixel_fetch.sv
// Background pixel fetch: ROM read of the colour index, palette lookup to RGB, and a matching
// delay line so coordinates and the draw flag leave aligned with the colour.
module bg_pixel_fetch #(
    parameter int ADDR_W   = 18,
    parameter int IDX_W    = 4,
    parameter int MEM_LAT  = 2,
    parameter int ADDR_MAX = 155306
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              drawBG,
    input  logic [ADDR_W-1:0] addrBG,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    bg_pixel_fetch_if.master  mem,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_waddr,
    input  logic [23:0]       pal_wdata,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              out_valid,
    output logic [9:0]        outX,
    output logic [9:0]        outY,
    output logic              oob_err
);
    localparam int L     = MEM_LAT + 2;
    localparam int PAL_N = 1 << IDX_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX_V = ADDR_W'(ADDR_MAX);

    // Grayscale ramp: each channel of entry i is the nibble i repeated.
    function automatic logic [23:0] ramp(input int i);
        logic [3:0] n;
        n = 4'(i);
        return {n, n, n, n, n, n};
    endfunction

    logic              in_bounds;
    logic              req;
    logic              oob_hit;

    logic              req_q [L];
    logic [9:0]        x_q   [L];
    logic [9:0]        y_q   [L];
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              oob_q, oob_d;
    logic [23:0]       pal_q [PAL_N];

    assign in_bounds = (addrBG <= ADDR_MAX_V);
    assign req       = drawBG && in_bounds;
    assign oob_hit   = drawBG && !in_bounds;

    // req_q[L-2] belongs to the pixel whose ROM data is on mem_data this cycle.
    always_comb begin
        mem_addr_d = mem_addr_q;
        oob_d      = oob_q | oob_hit;
        rgb_d      = '0;
        if (req) begin
            mem_addr_d = addrBG;
        end
        if (req_q[L-2]) begin
            rgb_d = pal_q[mem.mem_data];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < L; i++) begin
                req_q[i] <= 1'b0;
                x_q[i]   <= '0;
                y_q[i]   <= '0;
            end
            mem_addr_q <= '0;
            rgb_q      <= '0;
            oob_q      <= 1'b0;
        end else begin
            req_q[0] <= req;
            x_q[0]   <= DrawX;
            y_q[0]   <= DrawY;
            for (int i = 1; i < L; i++) begin
                req_q[i] <= req_q[i-1];
                x_q[i]   <= x_q[i-1];
                y_q[i]   <= y_q[i-1];
            end
            mem_addr_q <= mem_addr_d;
            rgb_q      <= rgb_d;
            oob_q      <= oob_d;
        end
    end

    // Lookup above reads the pre-edge entry, so a same-cycle write is seen only from the next cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal_q[i] <= ramp(i);
            end
        end else if (pal_we) begin
            pal_q[pal_waddr] <= pal_wdata;
        end
    end

    assign mem.mem_rd   = req_q[0];
    assign mem.mem_addr = mem_addr_q;
    assign Red          = rgb_q[23:16];
    assign Green        = rgb_q[15:8];
    assign Blue         = rgb_q[7:0];
    assign out_valid    = req_q[L-1];
    assign outX         = x_q[L-1];
    assign outY         = y_q[L-1];
    assign oob_err      = oob_q;
endmodule

// File: tb/tb_bg_pixel_fetch.sv
// Directed bench for bg_pixel_fetch: driver pushes expected outputs, negedge monitor pops and compares.
module tb_bg_pixel_fetch;
    localparam int MEM_LAT = 2;
    localparam int L       = MEM_LAT + 2;

    logic        clk;
    logic        rst_n;
    logic        drawBG;
    logic [17:0] addrBG;
    logic [9:0]  DrawX, DrawY;
    logic        pal_we;
    logic [3:0]  pal_waddr;
    logic [23:0] pal_wdata;
    logic [7:0]  Red, Green, Blue;
    logic        out_valid;
    logic [9:0]  outX, outY;
    logic        oob_err;

    int checks   = 0;
    int failures = 0;

    // {valid, rgb, x, y} and {mem_rd, mem_addr, oob_err}
    logic [44:0] exp_q[$];
    logic [19:0] mexp_q[$];

    logic [3:0]  rom_mem [int];
    logic [3:0]  rom_pipe [MEM_LAT];
    logic [17:0] last_addr;
    logic        oob_exp;
    int          cnt;

    bg_pixel_fetch_if #(.ADDR_W(18), .IDX_W(4)) mif ();

    bg_pixel_fetch #(.ADDR_W(18), .IDX_W(4), .MEM_LAT(MEM_LAT), .ADDR_MAX(155306)) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .drawBG    (drawBG),
        .addrBG    (addrBG),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .mem       (mif.master),
        .pal_we    (pal_we),
        .pal_waddr (pal_waddr),
        .pal_wdata (pal_wdata),
        .Red       (Red),
        .Green     (Green),
        .Blue      (Blue),
        .out_valid (out_valid),
        .outX      (outX),
        .outY      (outY),
        .oob_err   (oob_err)
    );

    // Clock and edge counter since reset release
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (cnt < 100000) cnt <= cnt + 1;
    end

    // ROM model: junk data unless a strobed read of a loaded word is in flight
    always @(posedge clk) begin
        if (mif.mem_rd && rom_mem.exists(int'(mif.mem_addr)))
            rom_pipe[0] <= rom_mem[int'(mif.mem_addr)];
        else
            rom_pipe[0] <= 4'($urandom);
        for (int i = 1; i < MEM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign mif.mem_data = rom_pipe[MEM_LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one pixel for one clock and queue its hand-computed expectations
    task automatic pix(input logic d, input logic [17:0] a, input logic [9:0] x, input logic [9:0] y,
                       input logic [3:0] rv, input logic ev, input logic [23:0] erg);
        drawBG = d;
        addrBG = a;
        DrawX  = x;
        DrawY  = y;
        if (ev) begin
            rom_mem[int'(a)] = rv;
            last_addr = a;
        end
        if (d && a > 18'd155306) oob_exp = 1'b1;
        exp_q.push_back({ev, erg, x, y});
        mexp_q.push_back({ev, last_addr, oob_exp});
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [44:0] e;
        logic [19:0] m;
        if (rst_n) begin
            if (cnt >= 1 && mexp_q.size() > 0) begin
                m = mexp_q.pop_front();
                chk("mem_rd", 64'(mif.mem_rd), 64'(m[19]));
                chk("mem_addr", 64'(mif.mem_addr), 64'(m[18:1]));
                chk("oob_err", 64'(oob_err), 64'(m[0]));
            end
            if (cnt >= L) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_valid", 64'(out_valid), 64'(e[44]));
                    chk("rgb", 64'({Red, Green, Blue}), 64'(e[43:20]));
                    chk("outX", 64'(outX), 64'(e[19:10]));
                    chk("outY", 64'(outY), 64'(e[9:0]));
                end
            end else begin
                chk("flushed_out", 64'({out_valid, Red, Green, Blue, outX, outY}), 64'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_rd"}, 64'(mif.mem_rd), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mif.mem_addr), 64'd0);
        chk({tag, "_rgb"}, 64'({Red, Green, Blue}), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_outXY"}, 64'({outX, outY}), 64'd0);
        chk({tag, "_oob_err"}, 64'(oob_err), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        drawBG    = 1'b0;
        addrBG    = '0;
        DrawX     = '0;
        DrawY     = '0;
        pal_we    = 1'b0;
        pal_waddr = '0;
        pal_wdata = '0;
        last_addr = '0;
        oob_exp   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single pixel, then idle cycles while mem_addr holds 1707
        pix(1'b1, 18'd1707, 10'd0, 10'd0, 4'd5, 1'b1, 24'h555555);
        for (int i = 0; i < 3; i++) pix(1'b0, 18'd0, 10'(100 + i), 10'd0, 4'd0, 1'b0, 24'h0);

        // Eight back-to-back pixels
        for (int i = 0; i < 8; i++)
            pix(1'b1, 18'(1707 + i), 10'(i), 10'd1, 4'(i), 1'b1, 24'(24'h111111 * i));

        // Blanking, out-of-bounds, and the last legal address
        pix(1'b0, 18'd1800, 10'd8, 10'd1, 4'd0, 1'b0, 24'h0);
        pix(1'b1, 18'd1801, 10'd9, 10'd1, 4'd9, 1'b1, 24'h999999);
        pix(1'b1, 18'd155307, 10'd10, 10'd1, 4'd0, 1'b0, 24'h0);
        pix(1'b1, 18'd155306, 10'd11, 10'd1, 4'hF, 1'b1, 24'hFFFFFF);
        pix(1'b0, 18'd0, 10'd12, 10'd1, 4'd0, 1'b0, 24'h0);

        // Palette write colliding with the lookup of the same entry
        pix(1'b1, 18'd2000, 10'd20, 10'd2, 4'd3, 1'b1, 24'h333333);
        pix(1'b0, 18'd0, 10'd21, 10'd2, 4'd0, 1'b0, 24'h0);
        pix(1'b0, 18'd0, 10'd22, 10'd2, 4'd0, 1'b0, 24'h0);
        pal_we    = 1'b1;
        pal_waddr = 4'd3;
        pal_wdata = 24'h123456;
        pix(1'b1, 18'd2001, 10'd23, 10'd2, 4'd3, 1'b1, 24'h123456);
        pal_we    = 1'b0;
        pix(1'b1, 18'd2002, 10'd24, 10'd2, 4'd4, 1'b1, 24'h444444);
        for (int i = 0; i < 3; i++)
            pix(1'b1, 18'(3000 + i), 10'(30 + i), 10'd3, 4'd3, 1'b1, 24'h123456);

        // Reset mid-stream: expectations still in flight are discarded
        rst_n = 1'b0;
        exp_q.delete();
        mexp_q.delete();
        last_addr = '0;
        oob_exp   = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pix(1'b1, 18'd3100, 10'd40, 10'd4, 4'd3, 1'b1, 24'h333333);
        pix(1'b1, 18'd3101, 10'd41, 10'd4, 4'd7, 1'b1, 24'h777777);
        pix(1'b0, 18'd0, 10'd42, 10'd4, 4'd0, 1'b0, 24'h0);

        drawBG = 1'b0;
        repeat (L + 2) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size() + mexp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
